fetch_decode: RTL and testbench
===============================

// Module: fetch_decode
// PURPOSE
//   IF/ID front end of the 3-bit program processor. Holds the program (3-bit words loaded serially
//   before run), fetches the opcode/operand pair at instr_ptr, decodes it into the operand/operation
//   selects and register write enables consumed by execute. Two registered stages (IF, ID) give
//   execute's 2-cycle start-up/halt delay.
// PARAMETERS
//   PROG_DEPTH  16  program words (3-bit each); instr_ptr[4] set means halt
// PORTS
//   clk             in   1  clock
//   rst             in   1  asynchronous active-high reset
//   prog_wr_en      in   1  append prog_wr_data to program memory (load phase)
//   prog_wr_data    in   3  program word
//   run             in   1  level; fetch enabled when high and prog_wr_en low
//   instr_ptr       in   5  fetch address (execute's next/jump address)
//   flush           in   1  taken jump in execute; squash IF and ID contents
//   prog_full       out  1  PROG_DEPTH words loaded
//   operand_id_reg  out  3  registered operand (literal / combo id)
//   op1_sel         out  2  operand 1 select
//   op2_sel         out  2  operand 2 select
//   operation_sel   out  2  SHIFT/XOR/MOD/JUMP
//   reg_wr_en       out  5  [0]A [1]B [2]C [3]out [4]reserved, always 0
//   dec_valid       out  1  ID stage holds a real instruction
// BEHAVIOUR
//   Reset: load pointer 0, memory all 0, all outputs 0 (reg_wr_en=0 is a bubble).
//   Load: each cycle with prog_wr_en writes mem[wptr], wptr++; writes with wptr==PROG_DEPTH dropped,
//     prog_full=1. Load while run high takes priority; fetch stalls that cycle (IF bubble).
//   IF (cycle n): if run && !instr_ptr[4] && !flush: opcode_q<=mem[ptr], operand_q<=mem[ptr+1]
//     (ptr+1 beyond PROG_DEPTH-1 reads 0), if_valid<=1; else if_valid<=0.
//   ID (cycle n+1): outputs registered from opcode_q/operand_q; dec_valid<=if_valid && !flush.
//     Invalid -> reg_wr_en=0, operation_sel=MOD_SEL, other fields 0. Latency ptr->ID outputs = 2.
//   Decode (op: op1_sel,op2_sel,operation_sel,reg_wr_en):
//     0 adv: COMBO,COMBO,SHIFT,A   1 bxl: REG_B,LIT,XOR,B   2 bst: COMBO,COMBO,MOD,B
//     3 jnz: LIT,LIT,JUMP,none     4 bxc: REG_B,REG_C,XOR,B 5 out: COMBO,COMBO,MOD,out
//     6 bdv: COMBO,COMBO,SHIFT,B   7 cdv: COMBO,COMBO,SHIFT,C
//   operand_id_reg = operand_q unchanged for all opcodes (bxc ignores it).
//   flush and halt same cycle: both squash; result is identical bubble.
//   Halt: instr_ptr[4]=1 -> IF bubbles; ID drains one cycle later; outputs hold bubble until rst.
//   Reset mid-run: immediate bubble outputs, program memory cleared, reload required.
// CONFIGURATION
//   FETCH_DECODE_INSTR_CNT_EN defined: adds output instr_cnt[15:0], +1 each cycle dec_valid=1,
//     saturates at 16'hFFFF, reset 0. Undefined: port and counter absent; all else identical.
// STRUCTURE
//   Shared package/include: select encodings COMBO_OP_SEL=0 LIT_OP_SEL=1 REG_B_SEL=2 REG_C_SEL=3,
//     SHIFT_SEL=0 XOR_SEL=1 MOD_SEL=2 JUMP_SEL=3, opcode constants 0..7, reg_wr_en bit indices.
//   One sub-module: prog_mem (PROG_DEPTH x 3 register file, 1 write, 2 async read ports).
//   Decode table is a combinational case inside fetch_decode, registered into ID.
// TESTING
//   Load 0,3,5,4,3,0 -> prog_full=0; ptr=0 run -> 2 cycles later operation_sel=SHIFT,
//     operand_id_reg=3, reg_wr_en=5'b00001, dec_valid=1.
//   Sweep opcodes 0..7 with operand 6 -> each decode row matches table exactly, operand_id_reg=6.
//   ptr=4 (jnz 0) then flush=1 for one cycle -> next ID output bubble (reg_wr_en=0, dec_valid=0).
//   ptr=15 with 16 words loaded -> operand_id_reg=0; 17th write dropped, prog_full=1.
//   ptr=16 -> dec_valid falls 2 cycles later and stays 0; rst asserted mid-run -> all outputs 0
//     asynchronously, mem reads 0.
//   With FETCH_DECODE_INSTR_CNT_EN: 5 valid decodes then halt -> instr_cnt=5 and holds.

Source files
------------

// File: rtl/fetch_decode_pkg.sv
// Shared encodings and stage bundles for the fetch_decode front end.
// Included by fetch_decode_if, fetch_decode_prog_mem and fetch_decode.
package fetch_decode_pkg;

    localparam int PTR_W  = 5;
    localparam int WORD_W = 3;
    localparam int CNT_W  = 16;

    localparam logic [1:0] COMBO_OP_SEL = 2'd0;
    localparam logic [1:0] LIT_OP_SEL   = 2'd1;
    localparam logic [1:0] REG_B_SEL    = 2'd2;
    localparam logic [1:0] REG_C_SEL    = 2'd3;

    localparam logic [1:0] SHIFT_SEL = 2'd0;
    localparam logic [1:0] XOR_SEL   = 2'd1;
    localparam logic [1:0] MOD_SEL   = 2'd2;
    localparam logic [1:0] JUMP_SEL  = 2'd3;

    localparam logic [2:0] OP_ADV = 3'd0;
    localparam logic [2:0] OP_BXL = 3'd1;
    localparam logic [2:0] OP_BST = 3'd2;
    localparam logic [2:0] OP_JNZ = 3'd3;
    localparam logic [2:0] OP_BXC = 3'd4;
    localparam logic [2:0] OP_OUT = 3'd5;
    localparam logic [2:0] OP_BDV = 3'd6;
    localparam logic [2:0] OP_CDV = 3'd7;

    localparam int WR_A    = 0;
    localparam int WR_B    = 1;
    localparam int WR_C    = 2;
    localparam int WR_OUT  = 3;
    localparam int WR_RSVD = 4;

    typedef struct packed {
        logic [WORD_W-1:0] opcode;
        logic [WORD_W-1:0] operand;
        logic              valid;
    } if_id_t;

    typedef struct packed {
        logic [WORD_W-1:0] operand;
        logic [1:0]        op1_sel;
        logic [1:0]        op2_sel;
        logic [1:0]        operation_sel;
        logic [4:0]        reg_wr_en;
        logic              valid;
    } id_ex_t;

    localparam id_ex_t ID_BUBBLE = '{
        operand:       '0,
        op1_sel:       COMBO_OP_SEL,
        op2_sel:       COMBO_OP_SEL,
        operation_sel: MOD_SEL,
        reg_wr_en:     '0,
        valid:         1'b0
    };

endpackage

// File: rtl/fetch_decode_if.sv
// Program-load, fetch-control and decoded-instruction bundle.
// instr_cnt exists only with FETCH_DECODE_INSTR_CNT_EN.
interface fetch_decode_if;
    import fetch_decode_pkg::*;

    logic              prog_wr_en;
    logic [WORD_W-1:0] prog_wr_data;
    logic              run;
    logic [PTR_W-1:0]  instr_ptr;
    logic              flush;
    logic              prog_full;
    logic [WORD_W-1:0] operand_id_reg;
    logic [1:0]        op1_sel;
    logic [1:0]        op2_sel;
    logic [1:0]        operation_sel;
    logic [4:0]        reg_wr_en;
    logic              dec_valid;
`ifdef FETCH_DECODE_INSTR_CNT_EN
    logic [CNT_W-1:0]  instr_cnt;
`endif

    modport master (
        output prog_wr_en,
        output prog_wr_data,
        output run,
        output instr_ptr,
        output flush,
        input  prog_full,
        input  operand_id_reg,
        input  op1_sel,
        input  op2_sel,
        input  operation_sel,
        input  reg_wr_en,
`ifdef FETCH_DECODE_INSTR_CNT_EN
        input  instr_cnt,
`endif
        input  dec_valid
    );

    modport slave (
        input  prog_wr_en,
        input  prog_wr_data,
        input  run,
        input  instr_ptr,
        input  flush,
        output prog_full,
        output operand_id_reg,
        output op1_sel,
        output op2_sel,
        output operation_sel,
        output reg_wr_en,
`ifdef FETCH_DECODE_INSTR_CNT_EN
        output instr_cnt,
`endif
        output dec_valid
    );

endinterface

// File: rtl/fetch_decode_prog_mem.sv
// Program register file: one write port, two async read ports.
// Addresses at or beyond DEPTH read as zero.
module fetch_decode_prog_mem
    import fetch_decode_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr0,
    input  logic [PTR_W-1:0]  raddr1,
    output logic [WORD_W-1:0] rdata0,
    output logic [WORD_W-1:0] rdata1
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr < DEPTH_P)) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    assign rdata0 = (raddr0 < DEPTH_P) ? mem[raddr0[AW-1:0]] : '0;
    assign rdata1 = (raddr1 < DEPTH_P) ? mem[raddr1[AW-1:0]] : '0;

endmodule

// File: rtl/fetch_decode.sv
// IF/ID front end: serial program load, two-word fetch, registered decode.
// Optional instr_cnt output under FETCH_DECODE_INSTR_CNT_EN.
module fetch_decode
    import fetch_decode_pkg::*;
#(
    parameter int PROG_DEPTH = 16
) (
    input logic           clk,
    input logic           rst,
    fetch_decode_if.slave fd
);

    localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(PROG_DEPTH);

    logic [PTR_W-1:0]  wptr;
    logic              prog_full;
    logic              wr_ok;
    logic              fetch_en;
    logic [PTR_W-1:0]  rd_addr0;
    logic [PTR_W-1:0]  rd_addr1;
    logic [WORD_W-1:0] opcode_rd;
    logic [WORD_W-1:0] operand_rd;
    if_id_t            if_q;
    id_ex_t            dec;
    id_ex_t            id_q;

    assign prog_full = (wptr == FULL_PTR);
    assign wr_ok     = fd.prog_wr_en && !prog_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
        end else if (wr_ok) begin
            wptr <= wptr + PTR_W'(1);
        end
    end

    // Bit 4 is the halt flag; the low bits address the word pair
    assign rd_addr0 = {1'b0, fd.instr_ptr[PTR_W-2:0]};
    assign rd_addr1 = rd_addr0 + PTR_W'(1);

    fetch_decode_prog_mem #(
        .DEPTH (PROG_DEPTH)
    ) u_prog_mem (
        .clk    (clk),
        .rst    (rst),
        .we     (wr_ok),
        .waddr  (wptr),
        .wdata  (fd.prog_wr_data),
        .raddr0 (rd_addr0),
        .raddr1 (rd_addr1),
        .rdata0 (opcode_rd),
        .rdata1 (operand_rd)
    );

    // Loading owns the cycle even while run is high
    assign fetch_en = fd.run
                   && !fd.prog_wr_en
                   && !fd.instr_ptr[PTR_W-1]
                   && !fd.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_q <= '0;
        end else if (fetch_en) begin
            if_q <= '{opcode: opcode_rd,
                      operand: operand_rd,
                      valid: 1'b1};
        end else begin
            if_q <= '0;
        end
    end

    always_comb begin
        dec         = '0;
        dec.operand = if_q.operand;
        dec.valid   = 1'b1;
        unique case (if_q.opcode)
            OP_ADV: begin
                dec.op1_sel         = COMBO_OP_SEL;
                dec.op2_sel         = COMBO_OP_SEL;
                dec.operation_sel   = SHIFT_SEL;
                dec.reg_wr_en[WR_A] = 1'b1;
            end
            OP_BXL: begin
                dec.op1_sel         = REG_B_SEL;
                dec.op2_sel         = LIT_OP_SEL;
                dec.operation_sel   = XOR_SEL;
                dec.reg_wr_en[WR_B] = 1'b1;
            end
            OP_BST: begin
                dec.op1_sel         = COMBO_OP_SEL;
                dec.op2_sel         = COMBO_OP_SEL;
                dec.operation_sel   = MOD_SEL;
                dec.reg_wr_en[WR_B] = 1'b1;
            end
            OP_JNZ: begin
                dec.op1_sel       = LIT_OP_SEL;
                dec.op2_sel       = LIT_OP_SEL;
                dec.operation_sel = JUMP_SEL;
            end
            OP_BXC: begin
                dec.op1_sel         = REG_B_SEL;
                dec.op2_sel         = REG_C_SEL;
                dec.operation_sel   = XOR_SEL;
                dec.reg_wr_en[WR_B] = 1'b1;
            end
            OP_OUT: begin
                dec.op1_sel           = COMBO_OP_SEL;
                dec.op2_sel           = COMBO_OP_SEL;
                dec.operation_sel     = MOD_SEL;
                dec.reg_wr_en[WR_OUT] = 1'b1;
            end
            OP_BDV: begin
                dec.op1_sel         = COMBO_OP_SEL;
                dec.op2_sel         = COMBO_OP_SEL;
                dec.operation_sel   = SHIFT_SEL;
                dec.reg_wr_en[WR_B] = 1'b1;
            end
            OP_CDV: begin
                dec.op1_sel         = COMBO_OP_SEL;
                dec.op2_sel         = COMBO_OP_SEL;
                dec.operation_sel   = SHIFT_SEL;
                dec.reg_wr_en[WR_C] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q <= '0;
        end else if (if_q.valid && !fd.flush) begin
            id_q <= dec;
        end else begin
            id_q <= ID_BUBBLE;
        end
    end

    assign fd.prog_full      = prog_full;
    assign fd.operand_id_reg = id_q.operand;
    assign fd.op1_sel        = id_q.op1_sel;
    assign fd.op2_sel        = id_q.op2_sel;
    assign fd.operation_sel  = id_q.operation_sel;
    assign fd.reg_wr_en      = id_q.reg_wr_en;
    assign fd.dec_valid      = id_q.valid;

`ifdef FETCH_DECODE_INSTR_CNT_EN
    logic [CNT_W-1:0] instr_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt <= '0;
        end else if (id_q.valid && (instr_cnt != '1)) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    assign fd.instr_cnt = instr_cnt;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: load, decode table, flush, halt, reset.
// Also checks instr_cnt when FETCH_DECODE_INSTR_CNT_EN is defined.
module tb_fetch_decode;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_decode_if fd ();

    fetch_decode dut (
        .clk (clk),
        .rst (rst),
        .fd  (fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] prog_a [6]  = '{3'd0, 3'd3, 3'd5, 3'd4, 3'd3, 3'd0};
    logic [1:0] e_op1  [8]  = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
    logic [1:0] e_op2  [8]  = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0};
    logic [1:0] e_oper [8]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [4:0] e_wr   [8]  = '{5'b00001, 5'b00010, 5'b00010, 5'b00000,
                                5'b00010, 5'b01000, 5'b00010, 5'b00100};

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_dec(input string tag,
                           input logic [1:0] op1,
                           input logic [1:0] op2,
                           input logic [1:0] oper,
                           input logic [4:0] wr,
                           input logic [2:0] opnd,
                           input logic       vld);
        chk({tag, ".op1"},   32'(fd.op1_sel),        32'(op1));
        chk({tag, ".op2"},   32'(fd.op2_sel),        32'(op2));
        chk({tag, ".oper"},  32'(fd.operation_sel),  32'(oper));
        chk({tag, ".wr"},    32'(fd.reg_wr_en),      32'(wr));
        chk({tag, ".opnd"},  32'(fd.operand_id_reg), 32'(opnd));
        chk({tag, ".valid"}, 32'(fd.dec_valid),      32'(vld));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        fd.prog_wr_en   = 1'b0;
        fd.prog_wr_data = '0;
        fd.run          = 1'b0;
        fd.instr_ptr    = '0;
        fd.flush        = 1'b0;

        #3;
        chk_dec("reset", 2'd0, 2'd0, 2'd0, 5'd0, 3'd0, 1'b0);
        chk("reset.full", 32'(fd.prog_full), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            fd.prog_wr_en   = 1'b1;
            fd.prog_wr_data = prog_a[i];
            @(negedge clk);
        end
        fd.prog_wr_en = 1'b0;
        chk("load6.full", 32'(fd.prog_full), 0);

        fd.instr_ptr = 5'd0;
        fd.run       = 1'b1;
        tick(2);
        chk_dec("adv3", 2'd0, 2'd0, 2'd0, 5'b00001, 3'd3, 1'b1);

        fd.instr_ptr = 5'd4;
        tick(2);
        chk_dec("jnz0", 2'd1, 2'd1, 2'd3, 5'd0, 3'd0, 1'b1);

        fd.flush = 1'b1;
        tick(1);
        chk_dec("flush", 2'd0, 2'd0, 2'd2, 5'd0, 3'd0, 1'b0);
        fd.flush = 1'b0;
        tick(1);
        chk("flush.if_squash", 32'(fd.dec_valid), 0);
        tick(1);
        chk("flush.refill", 32'(fd.dec_valid), 1);

        fd.instr_ptr = 5'd16;
        tick(1);
        chk("halt.drain", 32'(fd.dec_valid), 1);
        tick(1);
        chk_dec("halt", 2'd0, 2'd0, 2'd2, 5'd0, 3'd0, 1'b0);
        tick(5);
        chk("halt.hold", 32'(fd.dec_valid), 0);

        fd.instr_ptr = 5'd0;
        tick(2);
        chk("pre_rst.valid", 32'(fd.dec_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk_dec("mid_rst", 2'd0, 2'd0, 2'd0, 5'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        chk_dec("cleared0", 2'd0, 2'd0, 2'd0, 5'b00001, 3'd0, 1'b1);
        fd.instr_ptr = 5'd1;
        tick(2);
        chk_dec("cleared1", 2'd0, 2'd0, 2'd0, 5'b00001, 3'd0, 1'b1);

        fd.run = 1'b0;
        for (int op = 0; op < 8; op++) begin
            fd.prog_wr_en   = 1'b1;
            fd.prog_wr_data = 3'(op);
            @(negedge clk);
            fd.prog_wr_data = 3'd6;
            @(negedge clk);
        end
        fd.prog_wr_en = 1'b0;
        chk("load16.full", 32'(fd.prog_full), 1);

        fd.run       = 1'b1;
        fd.instr_ptr = 5'd2;
        tick(2);
        chk("pre_stall.valid", 32'(fd.dec_valid), 1);
        fd.prog_wr_en   = 1'b1;
        fd.prog_wr_data = 3'd7;
        tick(1);
        fd.prog_wr_en = 1'b0;
        chk("stall.id_hold", 32'(fd.dec_valid), 1);
        tick(1);
        chk("stall.bubble", 32'(fd.dec_valid), 0);
        chk("w17.full", 32'(fd.prog_full), 1);

        for (int op = 0; op < 8; op++) begin
            fd.instr_ptr = 5'(2 * op);
            tick(2);
            chk_dec($sformatf("op%0d", op),
                    e_op1[op], e_op2[op], e_oper[op], e_wr[op],
                    3'd6, 1'b1);
        end

        fd.instr_ptr = 5'd15;
        tick(2);
        chk_dec("ptr15", 2'd0, 2'd0, 2'd0, 5'b00010, 3'd0, 1'b1);

`ifdef FETCH_DECODE_INSTR_CNT_EN
        rst          = 1'b1;
        fd.run       = 1'b0;
        fd.instr_ptr = 5'd0;
        #1;
        chk("cnt.reset", 32'(fd.instr_cnt), 0);
        @(negedge clk);
        rst    = 1'b0;
        fd.run = 1'b1;
        tick(5);
        fd.instr_ptr = 5'd16;
        tick(10);
        chk("cnt.five", 32'(fd.instr_cnt), 5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
